// File: rtl/add_arbiter.sv
// add_arbiter: one shared WIDTH-bit adder serving N_REQ requesters.
// Requests are granted round-robin starting from ptr_q. Each grant then
// goes through three states: IDLE (grant and operand capture), CALC
// (register the sum) and RESP (hold the result until it is consumed).
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. Request side: req_ready[g] is a
// combinational accept strobe, high only in the IDLE cycle that grants g.
// Response side: resp_valid stays high with stable payload until the edge
// where resp_ready is sampled high.
module add_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_in1,
  input  logic [N_REQ*WIDTH-1:0] req_in2,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   resp_carry,
  input  logic                   resp_ready,
  output logic                   busy,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   g_q, g_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;

  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  int               cand;

  // Round-robin search: first valid requester at or above ptr_q, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(cand);
      end
    end
  end

  // Next-state, operand capture, sum and grant strobe.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    carry_d   = carry_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        // rst_n gating keeps the strobe low while reset holds the block.
        if (grant_any && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          g_d     = grant_idx;
          a_d     = req_in1[int'(grant_idx)*WIDTH +: WIDTH];
          b_d     = req_in2[int'(grant_idx)*WIDTH +: WIDTH];
          state_d = CALC;
        end
      end
      CALC: begin
        {carry_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
        state_d          = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          ptr_d   = (int'(g_q) == N_REQ - 1) ? '0 : g_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign resp_valid  = (state_q == RESP);
  assign resp_id     = g_q;
  assign resp_result = res_q;
  assign resp_carry  = carry_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
- REQ-001 Parameter `WIDTH`, default 32, SHALL set the operand and result width in bits.
- REQ-002 Parameter `N_REQ`, default 4, SHALL set the number of requesters; `IDW` = clog2(N_REQ), default 2.
- REQ-003 Port `clk`, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
- REQ-004 Port `rst_n`, input, 1 bit, SHALL be the reset: asynchronous, active-low.
- REQ-005 Port `req_valid`, input, N_REQ bits, SHALL carry one request-valid bit per requester.
- REQ-006 Port `req_in1`, input, N_REQ*WIDTH bits, SHALL carry operand 1; requester i uses bits [i*WIDTH +: WIDTH].
- REQ-007 Port `req_in2`, input, N_REQ*WIDTH bits, SHALL carry operand 2, packed the same way as `req_in1`.
- REQ-008 Port `req_ready`, output, N_REQ bits, SHALL be a one-hot grant/accept strobe.
- REQ-009 Port `resp_valid`, output, 1 bit, SHALL indicate that a result is presented.
- REQ-010 Port `resp_id`, output, IDW bits, SHALL give the index of the requester that owns the result.
- REQ-011 Port `resp_result`, output, WIDTH bits, SHALL give the sum, mod 2^WIDTH.
- REQ-012 Port `resp_carry`, output, 1 bit, SHALL give the carry out of the sum.
- REQ-013 Port `resp_ready`, input, 1 bit, SHALL indicate that the consumer accepts the result.
- REQ-014 Port `busy`, output, 1 bit, SHALL be high whenever the state is not IDLE.

Function
- REQ-015 The block SHALL share one WIDTH-bit adder (in1 + in2) among N_REQ requesters using an FSM with states IDLE, CALC and RESP.
- REQ-016 In IDLE with any `req_valid` bit set, the block SHALL grant the first set bit found searching upward from the round-robin pointer `ptr`, wrapping past N_REQ-1 to 0.
- REQ-017 The block SHALL assert `req_ready[g]` combinationally in that same IDLE cycle and only then; `req_ready` SHALL be all-zero in CALC and RESP.
- REQ-018 On the grant edge, the block SHALL latch operands `a` and `b` and the grant index `g`, and move to CALC.
- REQ-019 In CALC, the block SHALL register {carry, result} = a + b computed at WIDTH+1 bits, and move to RESP on the next edge.
- REQ-020 In RESP, the block SHALL assert `resp_valid` and hold `resp_id`, `resp_result` and `resp_carry` stable until `resp_ready` is sampled high.
- REQ-021 On the RESP edge where `resp_ready` is high, the block SHALL move to IDLE and set `ptr` = (g+1) mod N_REQ.
- REQ-022 Latency: the grant in cycle T SHALL produce `resp_valid` = 1 in cycle T+2; with `resp_ready` held high, the minimum spacing between grants SHALL be 3 cycles.
- REQ-023 In IDLE with no `req_valid` bit set, the block SHALL stay in IDLE with `ptr` unchanged and all `req_ready` bits low.
- REQ-024 Operands SHALL be sampled only on the grant edge; later changes on `req_in*` or `req_valid` SHALL NOT affect an operation in flight.
- REQ-025 Requesters SHALL hold `req_valid` and operands until their `req_ready` bit is seen high; a request deasserted before its grant is simply dropped.
- REQ-026 `resp_ready` SHALL be ignored in IDLE and CALC.
- REQ-027 Overflow SHALL wrap: 0xFFFFFFFF + 0x00000001 gives result 0x00000000 with carry 1.
- REQ-028 Multiple simultaneous requests SHALL be resolved by `ptr` order, which guarantees each requester is granted within N_REQ transactions.
- REQ-029 While `resp_valid` is high and `resp_ready` is low, the block SHALL accept no new requests; new requests stall until the result is consumed.

Reset
- REQ-030 When `rst_n` is low, the block SHALL force state to IDLE, `ptr` to 0, and `a`, `b`, `g`, result and carry registers to 0, independent of `clk`.
- REQ-031 During reset, outputs SHALL be: `resp_valid` = 0, `resp_id` = 0, `resp_result` = 0, `resp_carry` = 0, `busy` = 0, `req_ready` = 0.
- REQ-032 Reset asserted in CALC or RESP SHALL discard the in-flight operation with no response ever issued.
- REQ-033 After `rst_n` deasserts, the first grant SHALL search from index 0.

Verification
- REQ-034 Single request: `req_valid` = 0001 with in1 = 1, in2 = 2 -> `req_ready` = 0001 in cycle T; `resp_valid` = 1 in T+2 with `resp_id` = 0, `resp_result` = 3, `resp_carry` = 0.
- REQ-035 Overflow: requester 2 sends 0xFFFFFFFF + 0x00000001 -> `resp_result` = 0, `resp_carry` = 1, `resp_id` = 2.
- REQ-036 Fairness: `req_valid` = 1111 held, `resp_ready` = 1 -> grant order 0, 1, 2, 3, 0, each grant 3 cycles apart.
- REQ-037 Backpressure: `resp_ready` = 0 for 5 cycles in RESP -> outputs stable, `busy` = 1, no `req_ready`; `resp_ready` = 1 -> IDLE on the next edge, then the next grant.
- REQ-038 Reset mid-operation: `rst_n` low in CALC -> all outputs 0 immediately (asynchronously); after release, `req_valid` = 1111 grants requester 0 first.
- REQ-039 Operand change: requester 1 alters in1 in the cycle after its grant -> the result reflects the operands sampled at the grant.
